// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for imem_loader.
// Latency: none; this file only groups signals.
// Backpressure: InReady from the loader gates InValid/InByte from the source.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 6
);
   logic [7:0]            InByte;
   logic                  InValid;
   logic                  InReady;
   logic                  IMemWE;
   logic [ADDR_WIDTH-1:0] IMemAddr;
   logic [31:0]           IMemWD;
   logic                  CoreRun;
   logic                  Busy;
   logic                  Error;

   // loader side
   modport master (
      input  InByte, InValid,
      output InReady, IMemWE, IMemAddr, IMemWD, CoreRun, Busy, Error
   );

   // stream source, instruction memory and core side
   modport slave (
      output InByte, InValid,
      input  InReady, IMemWE, IMemAddr, IMemWD, CoreRun, Busy, Error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte stream (16-bit LE word count + LE words) -> sequential imem writes, then releases core.
// Latency: write strobe one cycle after the 4th byte of a word; CoreRun one cycle after entering DONE.
// Backpressure: InReady high in HDR0/HDR1/LOAD/CHK, low in DONE/ERR; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input logic           CLK,
   input logic           Reset,
   imem_loader_if.master bus
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   // Largest word count that fits the memory; held one bit wider than the header.
   localparam logic [16:0] N_MAX = 17'(1) << ADDR_WIDTH;

   // Where the stream goes once the payload (or an empty header) is finished.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CHK;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t                state_q;
   logic [7:0]            hdr_lo_q;
   logic [15:0]           word_cnt_q;
   logic [1:0]            byte_cnt_q;
   logic [23:0]           word_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [31:0]           wd_q;
   logic                  run_q;
   logic                  err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            xor_q;
`endif

   logic        active;
   logic        take;
   logic [15:0] n_d;
   logic [31:0] word_d;

   // Stream is open in every state except the two terminal ones.
   always_comb begin
      active = (state_q == S_HDR0) || (state_q == S_HDR1) ||
               (state_q == S_LOAD) || (state_q == S_CHK);
      take   = bus.InValid && active;
      n_d    = {bus.InByte, hdr_lo_q};
      word_d = {bus.InByte, word_q};
   end

   // Loader FSM with registered write port, run and error flags.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= S_HDR0;
         hdr_lo_q   <= 8'd0;
         word_cnt_q <= 16'd0;
         byte_cnt_q <= 2'd0;
         word_q     <= 24'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wd_q       <= 32'd0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= 8'd0;
`endif
      end else begin
         we_q  <= 1'b0;
         // One cycle behind DONE so the final write lands before the core fetches.
         run_q <= (state_q == S_DONE);
         if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ bus.InByte;
`endif
            case (state_q)
               S_HDR0: begin
                  hdr_lo_q <= bus.InByte;
                  state_q  <= S_HDR1;
               end
               S_HDR1: begin
                  word_cnt_q <= n_d;
                  if ({1'b0, n_d} > N_MAX) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else if (n_d == 16'd0) begin
                     state_q <= S_END;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     we_q       <= 1'b1;
                     waddr_q    <= addr_q;
                     wd_q       <= word_d;
                     addr_q     <= addr_q + ADDR_WIDTH'(1);
                     word_cnt_q <= word_cnt_q - 16'd1;
                     if (word_cnt_q == 16'd1) begin
                        state_q <= S_END;
                     end
                  end else begin
                     // Earlier bytes slide down so byte 0 ends in bits [7:0].
                     word_q <= {bus.InByte, word_q[23:8]};
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               S_CHK: begin
                  if (bus.InByte == xor_q) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
`endif
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.InReady  = active;
   assign bus.Busy     = active;
   assign bus.IMemWE   = we_q;
   assign bus.IMemAddr = waddr_q;
   assign bus.IMemWD   = wd_q;
   assign bus.CoreRun  = run_q;
   assign bus.Error    = err_q;

endmodule
